// File: rtl/pseudo_ana_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pseudo_ana_pkg
// Brief    : Shared types and helpers for the pseudo-analog stick emulator.
// Revision : 1.0 - initial release
// ============================================================================
package pseudo_ana_pkg;

    // Run-time behaviour selected by the MODE input (code 3 aliases centre)
    typedef enum logic [1:0] {
        MODE_CENTER = 2'd0,
        MODE_STICKY = 2'd1,
        MODE_ACCEL  = 2'd2
    } mode_t;

    // Sweep sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Per-axis direction encoding; both buttons pressed collapses to none
    localparam logic [1:0] c_dir_none = 2'b00;
    localparam logic [1:0] c_dir_pos  = 2'b01;
    localparam logic [1:0] c_dir_neg  = 2'b10;

    // Rest value of an unsigned axis output of width w
    function automatic int ctr(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Map the raw 2-bit MODE input onto mode_t
    function automatic mode_t decode_mode(input logic [1:0] m);
        mode_t r;
        case (m)
            2'd1:    r = MODE_STICKY;
            2'd2:    r = MODE_ACCEL;
            default: r = MODE_CENTER;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pseudo_ana_axis_step.sv
`default_nettype none
// ============================================================================
// Module   : pseudo_ana_axis_step
// Brief    : Combinational per-frame update of one axis: step, clamp, return
//            to centre without overshoot, and hold-counter bookkeeping.
// Revision : 1.0 - initial release
// ============================================================================
module pseudo_ana_axis_step
    import pseudo_ana_pkg::*;
#(
    parameter int PW    = 10,
    parameter int DELT  = 15,
    parameter int LIMIT = 120
)
(
    input  logic signed [PW-1:0] i_pos,
    input  logic        [1:0]    i_h,
    input  logic        [1:0]    i_dir,
    input  logic        [1:0]    i_last_dir,
    input  mode_t                i_mode,
    output logic signed [PW-1:0] o_pos,
    output logic        [1:0]    o_h,
    output logic        [1:0]    o_last_dir
);

    // Two guard bits so pos +/- 4*DELT never wraps before clamping
    localparam int c_aw = PW + 2;

    localparam logic signed [c_aw-1:0] c_step1 = c_aw'(DELT);
    localparam logic signed [c_aw-1:0] c_step2 = c_aw'(2 * DELT);
    localparam logic signed [c_aw-1:0] c_step3 = c_aw'(3 * DELT);
    localparam logic signed [c_aw-1:0] c_step4 = c_aw'(4 * DELT);
    localparam logic signed [c_aw-1:0] c_lim   = c_aw'(LIMIT);
    localparam logic signed [c_aw-1:0] c_nlim  = c_aw'(-LIMIT);

    localparam logic signed [PW-1:0] c_lim_p   = PW'(LIMIT);
    localparam logic signed [PW-1:0] c_nlim_p  = PW'(-LIMIT);
    localparam logic signed [PW-1:0] c_delt_p  = PW'(DELT);
    localparam logic signed [PW-1:0] c_ndelt_p = PW'(-DELT);

    logic signed [c_aw-1:0] w_pos_x;
    logic signed [c_aw-1:0] w_step;
    logic signed [c_aw-1:0] w_sum;
    logic        [1:0]      w_h_eff;
    logic                   w_same;

    // Position update: driven axes step and clamp, idle axes hold or decay
    always_comb begin
        w_pos_x = {{2{i_pos[PW-1]}}, i_pos};
        w_same  = (i_dir == i_last_dir);
        // A fresh press or a reversal restarts acceleration from the base step
        w_h_eff = w_same ? i_h : 2'd0;
        w_step  = c_step1;
        if (i_mode == MODE_ACCEL) begin
            case (w_h_eff)
                2'd1:    w_step = c_step2;
                2'd2:    w_step = c_step3;
                2'd3:    w_step = c_step4;
                default: w_step = c_step1;
            endcase
        end
        w_sum = (i_dir == c_dir_neg) ? (w_pos_x - w_step) : (w_pos_x + w_step);

        o_pos = i_pos;
        if (i_dir != c_dir_none) begin
            if (w_sum > c_lim) begin
                o_pos = c_lim_p;
            end else if (w_sum < c_nlim) begin
                o_pos = c_nlim_p;
            end else begin
                o_pos = w_sum[PW-1:0];
            end
        end else if (i_mode != MODE_STICKY) begin
            // Snap when within one step of centre so the axis never crosses it
            if ((i_pos <= c_delt_p) && (i_pos >= c_ndelt_p)) begin
                o_pos = '0;
            end else if (i_pos[PW-1]) begin
                o_pos = i_pos + c_delt_p;
            end else begin
                o_pos = i_pos - c_delt_p;
            end
        end
    end

    // Hold counter: counts frames the same direction was kept, saturating at 3
    always_comb begin
        o_last_dir = i_dir;
        if (i_dir == c_dir_none) begin
            o_h = 2'd0;
        end else if (w_same) begin
            o_h = (i_h == 2'd3) ? 2'd3 : (i_h + 2'd1);
        end else begin
            o_h = 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pseudo_ana_stk_multi.sv
`default_nettype none
// ============================================================================
// Module   : pseudo_ana_stk_multi
// Brief    : Multi-channel D-pad to pseudo-analog stick emulator. Once per
//            frame all axes are swept serially through one shared step unit.
// Revision : 1.0 - initial release
// ============================================================================
module pseudo_ana_stk_multi
    import pseudo_ana_pkg::*;
#(
    parameter int             NCH   = 2,
    parameter int             W     = 8,
    parameter int             DELT  = 15,
    parameter int             LIMIT = 120,
    parameter logic [NCH-1:0] INVX  = '0
)
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [8:0]         PV,
    input  logic [1:0]         MODE,
    input  logic [NCH*4-1:0]   DIR,
    output logic [NCH*W-1:0]   AX,
    output logic [NCH*W-1:0]   AY,
    output logic               BUSY
);

    localparam int               c_naxis  = 2 * NCH;
    localparam int               c_kw     = (c_naxis > 1) ? $clog2(c_naxis) : 1;
    localparam int               c_pw     = W + 2;
    localparam logic [c_kw-1:0]  c_k_last = c_kw'(c_naxis - 1);
    localparam logic [W-1:0]     c_center = W'(ctr(W));

    logic [8:0]              pv_q;
    state_t                  state_q,    state_d;
    logic [c_kw-1:0]         k_q,        k_d;
    logic                    pending_q,  pending_d;
    logic [NCH*4-1:0]        dir_snap_q, dir_snap_d;
    mode_t                   mode_snap_q, mode_snap_d;

    logic signed [c_pw-1:0]  pos_q  [c_naxis];
    logic signed [c_pw-1:0]  pos_d  [c_naxis];
    logic [1:0]              h_q    [c_naxis];
    logic [1:0]              h_d    [c_naxis];
    logic [1:0]              last_q [c_naxis];
    logic [1:0]              last_d [c_naxis];
    logic [W-1:0]            out_q  [c_naxis];
    logic [W-1:0]            out_d  [c_naxis];

    logic                    w_tick;
    logic                    w_snap;
    logic                    w_axis_we;
    logic [3:0]              w_nib;
    logic                    w_plus;
    logic                    w_minus;
    logic [1:0]              w_dir;
    logic signed [c_pw-1:0]  w_step_pos;
    logic [1:0]              w_step_h;
    logic [1:0]              w_step_last;

    // Frame tick: vertical counter has just wrapped to line 0
    always_comb begin
        w_tick = (PV == 9'd0) && (pv_q != 9'd0);
    end

    // Sweep sequencer: one axis per cycle, with a single-deep pending restart
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pending_d = pending_q;
        w_snap    = 1'b0;
        w_axis_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    state_d = ST_SWEEP;
                    k_d     = '0;
                    w_snap  = 1'b1;
                end
            end
            ST_SWEEP: begin
                w_axis_we = 1'b1;
                if (k_q == c_k_last) begin
                    if (pending_q || w_tick) begin
                        k_d       = '0;
                        w_snap    = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    k_d = k_q + c_kw'(1);
                    if (w_tick) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Freeze inputs at sweep start so a sweep sees one consistent frame
    always_comb begin
        dir_snap_d  = w_snap ? DIR : dir_snap_q;
        mode_snap_d = w_snap ? decode_mode(MODE) : mode_snap_q;
    end

    // Select the current axis buttons and reduce them to a signed direction
    always_comb begin
        w_nib = 4'd0;
        for (int c = 0; c < NCH; c++) begin
            if (c == int'(k_q >> 1)) begin
                w_nib = dir_snap_q[4*c +: 4];
            end
        end
        // Nibble is {UP,DW,LF,RG}; X grows with LF, Y grows with UP
        w_plus  = k_q[0] ? w_nib[3] : w_nib[1];
        w_minus = k_q[0] ? w_nib[2] : w_nib[0];
        if (w_plus && !w_minus) begin
            w_dir = c_dir_pos;
        end else if (w_minus && !w_plus) begin
            w_dir = c_dir_neg;
        end else begin
            w_dir = c_dir_none;
        end
    end

    pseudo_ana_axis_step #(
        .PW    (c_pw),
        .DELT  (DELT),
        .LIMIT (LIMIT)
    ) u_step (
        .i_pos      (pos_q[k_q]),
        .i_h        (h_q[k_q]),
        .i_dir      (w_dir),
        .i_last_dir (last_q[k_q]),
        .i_mode     (mode_snap_q),
        .o_pos      (w_step_pos),
        .o_h        (w_step_h),
        .o_last_dir (w_step_last)
    );

    // Write the shared step result back into the currently swept axis
    always_comb begin
        pos_d  = pos_q;
        h_d    = h_q;
        last_d = last_q;
        if (w_axis_we) begin
            pos_d[k_q]  = w_step_pos;
            h_d[k_q]    = w_step_h;
            last_d[k_q] = w_step_last;
        end
    end

    // Offset positions around centre; |pos| <= CENTER so W-bit math is exact
    always_comb begin
        for (int i = 0; i < c_naxis; i++) begin
            if (((i % 2) == 0) && INVX[i/2]) begin
                out_d[i] = c_center - pos_q[i][W-1:0];
            end else begin
                out_d[i] = c_center + pos_q[i][W-1:0];
            end
        end
    end

    // State registers; reset returns everything to centre immediately
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pv_q        <= 9'd0;
            state_q     <= ST_IDLE;
            k_q         <= '0;
            pending_q   <= 1'b0;
            dir_snap_q  <= '0;
            mode_snap_q <= MODE_CENTER;
            for (int i = 0; i < c_naxis; i++) begin
                pos_q[i]  <= '0;
                h_q[i]    <= 2'd0;
                last_q[i] <= c_dir_none;
                out_q[i]  <= c_center;
            end
        end else begin
            pv_q        <= PV;
            state_q     <= state_d;
            k_q         <= k_d;
            pending_q   <= pending_d;
            dir_snap_q  <= dir_snap_d;
            mode_snap_q <= mode_snap_d;
            for (int i = 0; i < c_naxis; i++) begin
                pos_q[i]  <= pos_d[i];
                h_q[i]    <= h_d[i];
                last_q[i] <= last_d[i];
                out_q[i]  <= out_d[i];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_pack
        assign AX[W*c +: W] = out_q[2*c];
        assign AY[W*c +: W] = out_q[2*c+1];
    end

    assign BUSY = (state_q == ST_SWEEP);

endmodule
`default_nettype wire

// File: tb/tb_pseudo_ana_stk_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pseudo_ana_stk_multi
// Brief    : Scoreboard bench: a 2-channel default instance and a 4-channel
//            instance (DELT=50, ch1 X mirrored) driven by directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pseudo_ana_stk_multi;

    localparam logic [31:0] C_ALL127 = 32'h7f7f_7f7f;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  pv_a  = 9'd5;
    logic [8:0]  pv_b  = 9'd5;
    logic [1:0]  mode_a = 2'd0;
    logic [1:0]  mode_b = 2'd0;
    logic [7:0]  dir_a = 8'h00;
    logic [15:0] dir_b = 16'h0000;
    logic [15:0] ax_a, ay_a;
    logic [31:0] ax_b, ay_b;
    logic        busy_a, busy_b;

    int nvec = 0;
    int nerr = 0;
    int first_chg;
    int busy_cnt;

    logic [31:0] q_a [$];
    logic [63:0] q_b [$];
    logic [31:0] exp_a;
    logic [63:0] exp_b;
    bit a_prev = 1'b0, a_pend = 1'b0;
    bit b_prev = 1'b0, b_pend = 1'b0;

    pseudo_ana_stk_multi #(
        .NCH(2), .W(8), .DELT(15), .LIMIT(120), .INVX(2'b00)
    ) u_dut_a (
        .CLK(clk), .RESET_N(rst_n), .PV(pv_a), .MODE(mode_a), .DIR(dir_a),
        .AX(ax_a), .AY(ay_a), .BUSY(busy_a)
    );

    pseudo_ana_stk_multi #(
        .NCH(4), .W(8), .DELT(50), .LIMIT(120), .INVX(4'b0010)
    ) u_dut_b (
        .CLK(clk), .RESET_N(rst_n), .PV(pv_b), .MODE(mode_b), .DIR(dir_b),
        .AX(ax_b), .AY(ay_b), .BUSY(busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] p4(input logic [7:0] v0, v1, v2, v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one frame on instance A and queue the values expected after its sweep
    task automatic frame_a(input logic [7:0] dir, input logic [1:0] mode,
                           input logic [7:0] ax0, ay0, ax1, ay1);
        @(negedge clk);
        dir_a  = dir;
        mode_a = mode;
        pv_a   = 9'd5;
        q_a.push_back({ax1, ax0, ay1, ay0});
        repeat (2) @(negedge clk);
        pv_a = 9'd0;
        repeat (12) @(negedge clk);
    endtask

    // Start a frame on instance B; the next rising edge samples the tick
    task automatic start_b(input logic [15:0] dir, input logic [1:0] mode,
                           input logic [31:0] ax, input logic [31:0] ay);
        @(negedge clk);
        dir_b  = dir;
        mode_b = mode;
        pv_b   = 9'd5;
        q_b.push_back({ax, ay});
        repeat (2) @(negedge clk);
        pv_b = 9'd0;
    endtask

    task automatic frame_b(input logic [15:0] dir, input logic [1:0] mode,
                           input logic [31:0] ax, input logic [31:0] ay);
        start_b(dir, mode, ax, ay);
        repeat (14) @(negedge clk);
    endtask

    // Monitor A: one cycle after BUSY falls every axis has been written out
    initial begin
        forever begin
            @(negedge clk);
            if (a_pend) begin
                nvec++;
                if (q_a.size() == 0) begin
                    nerr++;
                    $display("FAIL scb_a: unexpected sweep, actual=%h", {ax_a, ay_a});
                end else begin
                    exp_a = q_a.pop_front();
                    if ({ax_a, ay_a} !== exp_a) begin
                        nerr++;
                        $display("FAIL scb_a: actual AX/AY=%h required=%h", {ax_a, ay_a}, exp_a);
                    end
                end
            end
            a_pend = a_prev && !busy_a;
            a_prev = busy_a;
        end
    end

    // Monitor B
    initial begin
        forever begin
            @(negedge clk);
            if (b_pend) begin
                nvec++;
                if (q_b.size() == 0) begin
                    nerr++;
                    $display("FAIL scb_b: unexpected sweep, actual=%h", {ax_b, ay_b});
                end else begin
                    exp_b = q_b.pop_front();
                    if ({ax_b, ay_b} !== exp_b) begin
                        nerr++;
                        $display("FAIL scb_b: actual AX/AY=%h required=%h", {ax_b, ay_b}, exp_b);
                    end
                end
            end
            b_pend = b_prev && !busy_b;
            b_prev = busy_b;
        end
    end

    initial begin
        #500000;
        nerr++;
        $display("FAIL watchdog: run did not complete, vectors=%0d", nvec);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ax_a",   {48'd0, ax_a}, {48'd0, 16'h7f7f});
        chk("rst_ay_a",   {48'd0, ay_a}, {48'd0, 16'h7f7f});
        chk("rst_busy_a", {63'd0, busy_a}, 64'd0);
        chk("rst_ax_b",   {32'd0, ax_b}, {32'd0, C_ALL127});
        chk("rst_busy_b", {63'd0, busy_b}, 64'd0);
        rst_n = 1'b1;

        // Idle frame leaves outputs centred
        frame_a(8'h00, 2'd0, 8'd127, 8'd127, 8'd127, 8'd127);

        // Self-centre: LF held 9 frames, then released
        for (int i = 1; i <= 9; i++) begin
            int p;
            p = (15 * i > 120) ? 120 : 15 * i;
            frame_a(8'h02, 2'd0, 8'(127 + p), 8'd127, 8'd127, 8'd127);
        end
        for (int j = 1; j <= 9; j++) begin
            int p;
            p = (120 - 15 * j < 0) ? 0 : 120 - 15 * j;
            frame_a(8'h00, 2'd0, 8'(127 + p), 8'd127, 8'd127, 8'd127);
        end

        // Accelerate: UP steps 15,30,45,60 (clamped), reversal restarts at 15
        frame_a(8'h08, 2'd2, 8'd127, 8'd142, 8'd127, 8'd127);
        frame_a(8'h08, 2'd2, 8'd127, 8'd172, 8'd127, 8'd127);
        frame_a(8'h08, 2'd2, 8'd127, 8'd217, 8'd127, 8'd127);
        frame_a(8'h08, 2'd2, 8'd127, 8'd247, 8'd127, 8'd127);
        frame_a(8'h04, 2'd2, 8'd127, 8'd232, 8'd127, 8'd127);
        for (int j = 1; j <= 7; j++) begin
            frame_a(8'h00, 2'd2, 8'd127, 8'(232 - 15 * j), 8'd127, 8'd127);
        end

        // SOCD: LF+RG neutral on X while Y keeps climbing
        frame_a(8'h0a, 2'd0, 8'd142, 8'd142, 8'd127, 8'd127);
        frame_a(8'h0b, 2'd0, 8'd127, 8'd157, 8'd127, 8'd127);
        frame_a(8'h0b, 2'd0, 8'd127, 8'd172, 8'd127, 8'd127);
        frame_a(8'h00, 2'd0, 8'd127, 8'd157, 8'd127, 8'd127);
        frame_a(8'h00, 2'd0, 8'd127, 8'd142, 8'd127, 8'd127);
        frame_a(8'h00, 2'd0, 8'd127, 8'd127, 8'd127, 8'd127);

        // Channel 1 negative direction
        frame_a(8'h10, 2'd0, 8'd127, 8'd127, 8'd112, 8'd127);
        frame_a(8'h00, 2'd0, 8'd127, 8'd127, 8'd127, 8'd127);

        // Instance B, DELT=50: snap without overshoot, sticky, mode 3 as centre
        frame_b(16'h0002, 2'd0, p4(177, 127, 127, 127), C_ALL127);
        frame_b(16'h0002, 2'd0, p4(227, 127, 127, 127), C_ALL127);
        frame_b(16'h0002, 2'd0, p4(247, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd0, p4(197, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd0, p4(147, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd0, C_ALL127, C_ALL127);
        frame_b(16'h0002, 2'd1, p4(177, 127, 127, 127), C_ALL127);
        frame_b(16'h0002, 2'd1, p4(227, 127, 127, 127), C_ALL127);
        frame_b(16'h0002, 2'd1, p4(247, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd1, p4(247, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd1, p4(247, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd3, p4(197, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd3, p4(147, 127, 127, 127), C_ALL127);
        frame_b(16'h0000, 2'd3, C_ALL127, C_ALL127);

        // Latency: ch3 Y is the last axis, so it lands at edge tick+9
        start_b(16'h8000, 2'd0, C_ALL127, p4(127, 127, 127, 177));
        first_chg = -1;
        busy_cnt  = 0;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (busy_b) busy_cnt++;
            if ((first_chg < 0) && (ay_b[31:24] != 8'd127)) first_chg = i;
        end
        chk("b_ay3_latency", 64'(first_chg), 64'd9);
        chk("b_busy_len",    64'(busy_cnt),  64'd8);
        chk("b_other_axes",  {8'd0, ax_b, ay_b[23:0]}, {8'd0, C_ALL127, 24'h7f7f7f});

        // Second tick mid-sweep: one back-to-back re-sweep with fresh inputs
        start_b(16'h8000, 2'd0, p4(177, 127, 127, 127), p4(127, 127, 127, 177));
        busy_cnt = 0;
        for (int i = 0; i <= 19; i++) begin
            @(negedge clk);
            if (busy_b) busy_cnt++;
            if (i == 1) pv_b = 9'd5;
            if (i == 2) begin
                pv_b  = 9'd0;
                dir_b = 16'h0002;
            end
        end
        chk("b_resweep_busy_len", 64'(busy_cnt), 64'd16);

        // Mirrored X on channel 1
        frame_b(16'h0020, 2'd0, p4(127, 77, 127, 127), C_ALL127);

        // Asynchronous reset in the middle of a sweep
        start_b(16'h0020, 2'd0, C_ALL127, C_ALL127);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ax_b",   {32'd0, ax_b}, {32'd0, C_ALL127});
        chk("midrst_ay_b",   {32'd0, ay_b}, {32'd0, C_ALL127});
        chk("midrst_busy_b", {63'd0, busy_b}, 64'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // Cleared positions stay centred on the next frame
        frame_a(8'h00, 2'd0, 8'd127, 8'd127, 8'd127, 8'd127);
        frame_b(16'h0000, 2'd0, C_ALL127, C_ALL127);

        repeat (5) @(negedge clk);
        chk("q_a_drained", 64'(q_a.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
